// File: rtl/md_sched.sv
// Multiply/divide scheduler: owns HI/LO and runs mult/multu/div/divu as
// fixed-latency operations, raising busy/stall while one is in flight.
module md_sched #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  md_op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic [31:0] wdata,
  input  logic        d_is_md,
  output logic        busy,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic {
    IDLE,
    RUN
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] pending_hi_q, pending_hi_d;
  logic [31:0] pending_lo_q, pending_lo_d;
  logic        div0_q, div0_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic        is_div;
  logic        is_signed;
  logic [63:0] op_a64;
  logic [63:0] op_b64;
  logic [63:0] product;
  logic        neg_a;
  logic        neg_b;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [31:0] divisor;
  logic [31:0] uquot;
  logic [31:0] urem;
  logic [31:0] quot;
  logic [31:0] rem;

  // Signed divide is done on magnitudes so the 0x80000000 / -1 overflow and
  // a zero divisor never reach a native signed divider.
  always_comb begin
    is_div    = md_op[1];
    is_signed = ~md_op[0];

    op_a64  = is_signed ? {{32{src_a[31]}}, src_a} : {32'h0, src_a};
    op_b64  = is_signed ? {{32{src_b[31]}}, src_b} : {32'h0, src_b};
    product = op_a64 * op_b64;

    neg_a   = is_signed & src_a[31];
    neg_b   = is_signed & src_b[31];
    mag_a   = neg_a ? (~src_a + 32'd1) : src_a;
    mag_b   = neg_b ? (~src_b + 32'd1) : src_b;
    divisor = (mag_b == '0) ? 32'd1 : mag_b;
    uquot   = mag_a / divisor;
    urem    = mag_a % divisor;
    quot    = (neg_a ^ neg_b) ? (~uquot + 32'd1) : uquot;
    rem     = neg_a ? (~urem + 32'd1) : urem;
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pending_hi_d = pending_hi_q;
    pending_lo_d = pending_lo_q;
    div0_d       = div0_q;
    hi_d         = hi_q;
    lo_d         = lo_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (is_div) begin
            pending_hi_d = rem;
            pending_lo_d = quot;
            div0_d       = (src_b == '0);
            cnt_d        = 4'(DIV_CYCLES);
          end else begin
            pending_hi_d = product[63:32];
            pending_lo_d = product[31:0];
            div0_d       = 1'b0;
            cnt_d        = 4'(MULT_CYCLES);
          end
          state_d = RUN;
        end else begin
          if (mthi) hi_d = wdata;
          if (mtlo) lo_d = wdata;
        end
      end
      RUN: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          if (!div0_q) begin
            hi_d = pending_hi_q;
            lo_d = pending_lo_q;
          end
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      pending_hi_q <= '0;
      pending_lo_q <= '0;
      div0_q       <= 1'b0;
      hi_q         <= '0;
      lo_q         <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pending_hi_q <= pending_hi_d;
      pending_lo_q <= pending_lo_d;
      div0_q       <= div0_d;
      hi_q         <= hi_d;
      lo_q         <= lo_d;
    end
  end

  assign busy  = (state_q == RUN);
  assign stall = d_is_md & (busy | start);
  assign hi    = hi_q;
  assign lo    = lo_q;

endmodule

// File: tb/tb_md_sched.sv
// Directed bench for md_sched: HI/LO moves, mult/div results and latency,
// divide-by-zero, overflow, stall generation and mid-operation reset.
module tb_md_sched;

  logic        clk;
  logic        reset;
  logic        start;
  logic [1:0]  md_op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        mthi;
  logic        mtlo;
  logic [31:0] wdata;
  logic        d_is_md;
  logic        busy;
  logic        stall;
  logic [31:0] hi;
  logic [31:0] lo;

  int tests;
  int fails;
  logic [31:0] cur_hi;
  logic [31:0] cur_lo;

  md_sched #(
    .MULT_CYCLES(5),
    .DIV_CYCLES (10)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .md_op  (md_op),
    .src_a  (src_a),
    .src_b  (src_b),
    .mthi   (mthi),
    .mtlo   (mtlo),
    .wdata  (wdata),
    .d_is_md(d_is_md),
    .busy   (busy),
    .stall  (stall),
    .hi     (hi),
    .lo     (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Issues one operation and checks busy/HI/LO on every cycle up to commit.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int n,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    md_op = op;
    src_a = a;
    src_b = b;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < n; k++) begin
      check({tag, "_busy"}, {31'h0, busy}, 32'h1);
      check({tag, "_hold_hi"}, hi, cur_hi);
      check({tag, "_hold_lo"}, lo, cur_lo);
      tick();
    end
    check({tag, "_done"}, {31'h0, busy}, 32'h0);
    check({tag, "_hi"}, hi, exp_hi);
    check({tag, "_lo"}, lo, exp_lo);
    cur_hi = exp_hi;
    cur_lo = exp_lo;
  endtask

  initial begin
    tests   = 0;
    fails   = 0;
    reset   = 1'b1;
    start   = 1'b0;
    md_op   = 2'b00;
    src_a   = '0;
    src_b   = '0;
    mthi    = 1'b0;
    mtlo    = 1'b0;
    wdata   = '0;
    d_is_md = 1'b0;
    tick();
    tick();
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_hi", hi, 32'h0);
    check("rst_lo", lo, 32'h0);
    reset = 1'b0;

    mthi  = 1'b1;
    wdata = 32'h12345678;
    tick();
    check("mthi_hi", hi, 32'h12345678);
    check("mthi_busy", {31'h0, busy}, 32'h0);
    mthi  = 1'b0;
    mtlo  = 1'b1;
    wdata = 32'h9ABCDEF0;
    tick();
    mtlo = 1'b0;
    check("mtlo_lo", lo, 32'h9ABCDEF0);
    check("mtlo_hi", hi, 32'h12345678);
    check("mtlo_busy", {31'h0, busy}, 32'h0);
    cur_hi = 32'h12345678;
    cur_lo = 32'h9ABCDEF0;

    run_op("mult", 2'b00, 32'hFFFFFFFE, 32'd3, 5, 32'hFFFFFFFF, 32'hFFFFFFFA);
    run_op("multu", 2'b01, 32'hFFFFFFFE, 32'd3, 5, 32'h00000002, 32'hFFFFFFFA);
    run_op("div", 2'b10, 32'hFFFFFFF9, 32'd2, 10, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("divu0", 2'b11, 32'd7, 32'd0, 10, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("divovf", 2'b10, 32'h80000000, 32'hFFFFFFFF, 10, 32'h00000000, 32'h80000000);

    // stall with a HI/LO instruction waiting in D
    d_is_md = 1'b1;
    md_op   = 2'b00;
    src_a   = 32'h00010000;
    src_b   = 32'h00010000;
    start   = 1'b1;
    #1;
    check("stall_start", {31'h0, stall}, 32'h1);
    tick();
    start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      check("stall_busy", {31'h0, stall}, 32'h1);
      tick();
    end
    check("stall_release", {31'h0, stall}, 32'h0);
    check("stall_busy_end", {31'h0, busy}, 32'h0);
    check("stall_lo", lo, 32'h0);
    check("stall_hi", hi, 32'h1);
    cur_hi = 32'h1;
    cur_lo = 32'h0;

    // no stall when D holds an unrelated instruction
    d_is_md = 1'b0;
    start   = 1'b1;
    src_a   = 32'd3;
    src_b   = 32'd4;
    #1;
    check("nostall_start", {31'h0, stall}, 32'h0);
    tick();
    start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      check("nostall_busy", {31'h0, stall}, 32'h0);
      tick();
    end
    check("nostall_hi", hi, 32'h0);
    check("nostall_lo", lo, 32'd12);
    cur_hi = 32'h0;
    cur_lo = 32'd12;

    // mtlo with start, then during RUN: both ignored
    md_op = 2'b00;
    src_a = 32'd6;
    src_b = 32'd7;
    start = 1'b1;
    mtlo  = 1'b1;
    mthi  = 1'b1;
    wdata = 32'hDEADBEEF;
    tick();
    start = 1'b0;
    check("mtlo_start_lo", lo, 32'd12);
    check("mthi_start_hi", hi, 32'h0);
    tick();
    check("mtlo_run_lo", lo, 32'd12);
    mtlo = 1'b0;
    mthi = 1'b0;
    for (int k = 0; k < 3; k++) tick();
    check("mtlo_run_busy", {31'h0, busy}, 32'h1);
    tick();
    check("mtlo_done_busy", {31'h0, busy}, 32'h0);
    check("mtlo_done_lo", lo, 32'd42);
    check("mtlo_done_hi", hi, 32'h0);
    cur_hi = 32'h0;
    cur_lo = 32'd42;

    // reset at the third busy cycle of a divide
    md_op = 2'b10;
    src_a = 32'd100;
    src_b = 32'd7;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    check("abort_busy_pre", {31'h0, busy}, 32'h1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_busy", {31'h0, busy}, 32'h0);
    check("abort_hi", hi, 32'h0);
    check("abort_lo", lo, 32'h0);
    cur_hi = 32'h0;
    cur_lo = 32'h0;
    run_op("post_rst", 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 5, 32'h00000000, 32'h00000001);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
